axi4lite_regfile_slave: RTL and testbench

- AXI4-Lite responder exposing a bank of N_REGS 32-bit read/write control registers.
- Sits on the video generator's CTRL bus, opposite a ROM-driven AXI4-Lite configuration master.
- Presents register contents as a flat vector, plus per-register write strobes for downstream timing and pattern logic.
- Independent write and read paths. One outstanding transaction per direction.

---
 rtl/axi4lite_regfile_slave_if.sv | 62 ++++++
 rtl/axi4lite_regfile_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4lite_regfile_slave.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_regfile_slave_if.sv
// AXI4-Lite bus bundle for the CTRL register port.
// The master modport drives addresses, data and response-ready signals.
// The slave modport drives the ready signals and the responses.
interface axi4lite_regfile_slave_if #(
    parameter int ADDRW = 8,
    parameter int DATAW = 32
) ();

    // Write address channel
    logic [ADDRW-1:0]     awaddr;
    logic                 awvalid;
    logic                 awready;

    // Write data channel
    logic [DATAW-1:0]     wdata;
    logic [DATAW/8-1:0]   wstrb;
    logic                 wvalid;
    logic                 wready;

    // Write response channel
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    // Read address channel
    logic [ADDRW-1:0]     araddr;
    logic                 arvalid;
    logic                 arready;

    // Read data channel
    logic [DATAW-1:0]     rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite responder for a bank of N_REGS 32-bit control registers.
// The write path buffers one AW beat and one W beat independently and
// commits them together on the edge after both are present. The read path
// answers one AR beat at a time. Register contents leave as a flat vector,
// along with a one-cycle pulse per register on every committed write.
module axi4lite_regfile_slave #(
    parameter int              N_REGS    = 8,
    parameter int              ADDRW     = 8,
    parameter int              DATAW     = 32,
    parameter logic [31:0]     RESET_VAL = 32'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    axi4lite_regfile_slave_if.slave    s_axi_ctrl,
    output logic [N_REGS*DATAW-1:0]    regs_o,
    output logic [N_REGS-1:0]          wr_pulse_o
);

    localparam int               IDXW      = ADDRW - 2;
    localparam int               NLANES    = DATAW / 8;
    localparam logic [IDXW:0]    IDX_LIMIT = (IDXW+1)'(N_REGS);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    // Elaboration-time guard on the geometry this block supports.
    if (DATAW != 32) begin : g_bad_dataw
        $error("axi4lite_regfile_slave: DATAW must be 32");
    end
    if (N_REGS > (1 << IDXW)) begin : g_bad_nregs
        $error("axi4lite_regfile_slave: N_REGS exceeds the address space");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                     init_reg;

    logic                     aw_full_reg;
    logic [IDXW-1:0]          aw_idx_reg;
    logic                     w_full_reg;
    logic [DATAW-1:0]         w_data_reg;
    logic [NLANES-1:0]        w_strb_reg;
    logic                     bvalid_reg;
    logic [1:0]               bresp_reg;

    logic                     rvalid_reg;
    logic [1:0]               rresp_reg;
    logic [DATAW-1:0]         rdata_reg;

    logic [N_REGS-1:0]        wr_pulse_reg;
    logic [N_REGS*DATAW-1:0]  regs_flat;

    // ------------------------------------------------------------------
    // Combinational handshake and decode signals
    // ------------------------------------------------------------------
    logic                     awready_c;
    logic                     wready_c;
    logic                     arready_c;
    logic                     aw_hs;
    logic                     w_hs;
    logic                     b_hs;
    logic                     ar_hs;
    logic                     r_hs;
    logic                     commit;
    logic                     aw_in_range;
    logic [IDXW-1:0]          ar_idx;
    logic                     ar_in_range;
    logic [DATAW-1:0]         rd_mux;
    logic [N_REGS-1:0]        hit_vec;
    logic                     unused_addr_lsbs;

    // Ready generation, handshake detection and address decode.
    always_comb begin
        awready_c   = init_reg & ~aw_full_reg & ~bvalid_reg;
        wready_c    = init_reg & ~w_full_reg  & ~bvalid_reg;
        arready_c   = init_reg & ~rvalid_reg;

        aw_hs       = s_axi_ctrl.awvalid & awready_c;
        w_hs        = s_axi_ctrl.wvalid  & wready_c;
        b_hs        = bvalid_reg & s_axi_ctrl.bready;
        ar_hs       = s_axi_ctrl.arvalid & arready_c;
        r_hs        = rvalid_reg & s_axi_ctrl.rready;

        // Both halves of the write are present and the response slot is free.
        commit      = aw_full_reg & w_full_reg & ~bvalid_reg;
        aw_in_range = ({1'b0, aw_idx_reg} < IDX_LIMIT);

        ar_idx      = s_axi_ctrl.araddr[ADDRW-1:2];
        ar_in_range = ({1'b0, ar_idx} < IDX_LIMIT);
    end

    // Byte-offset bits of both addresses carry no meaning for word registers.
    assign unused_addr_lsbs = ^{s_axi_ctrl.awaddr[1:0], s_axi_ctrl.araddr[1:0]};

    // One-hot commit target; out-of-range indices match no bit, so they
    // neither write a register nor raise a pulse.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < N_REGS; i++) begin
            hit_vec[i] = commit && (aw_idx_reg == IDXW'(i));
        end
    end

    // Read mux: selected register, or zero for an out-of-range index.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (ar_idx == IDXW'(i)) begin
                rd_mux = regs_flat[i*DATAW +: DATAW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Holds all ready signals low until the first edge after reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_reg <= 1'b0;
        end else begin
            init_reg <= 1'b1;
        end
    end

    // Write path: AW/W holding buffers, commit and write response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_full_reg <= 1'b0;
            aw_idx_reg  <= '0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else if (commit) begin
            // Readies are low while both buffers are full, so no new beat
            // can arrive on the commit edge.
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                aw_idx_reg  <= s_axi_ctrl.awaddr[ADDRW-1:2];
            end
            if (w_hs) begin
                w_full_reg  <= 1'b1;
                w_data_reg  <= s_axi_ctrl.wdata;
                w_strb_reg  <= s_axi_ctrl.wstrb;
            end
            if (b_hs) begin
                bvalid_reg  <= 1'b0;
            end
        end
    end

    // One-cycle commit pulse per register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_pulse_reg <= '0;
        end else begin
            wr_pulse_reg <= hit_vec;
        end
    end

    // Register storage, one byte-enabled word per generate slice.
    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
        logic [DATAW-1:0] word_reg;

        // Byte-lane write on commit; lanes with a clear strobe keep their value.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                word_reg <= RESET_VAL;
            end else if (hit_vec[gi]) begin
                for (int b = 0; b < NLANES; b++) begin
                    if (w_strb_reg[b]) begin
                        word_reg[b*8 +: 8] <= w_data_reg[b*8 +: 8];
                    end
                end
            end
        end

        assign regs_flat[gi*DATAW +: DATAW] = word_reg;
    end

    // Read path: capture data on AR handshake, hold until R handshake.
    // The capture sees pre-edge register values, so a same-edge commit
    // to the same register returns the old contents.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_reg  <= rd_mux;
        end else if (r_hs) begin
            rvalid_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_ctrl.awready = awready_c;
    assign s_axi_ctrl.wready  = wready_c;
    assign s_axi_ctrl.bvalid  = bvalid_reg;
    assign s_axi_ctrl.bresp   = bresp_reg;
    assign s_axi_ctrl.arready = arready_c;
    assign s_axi_ctrl.rvalid  = rvalid_reg;
    assign s_axi_ctrl.rresp   = rresp_reg;
    assign s_axi_ctrl.rdata   = rdata_reg;

    assign regs_o     = regs_flat;
    assign wr_pulse_o = wr_pulse_reg;

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Directed testbench for axi4lite_regfile_slave (N_REGS=8, ADDRW=8).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_axi4lite_regfile_slave;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    axi4lite_regfile_slave_if #(.ADDRW(8), .DATAW(32)) bus ();

    logic [255:0] regs_o;
    logic [7:0]   wr_pulse_o;

    axi4lite_regfile_slave #(
        .N_REGS    (8),
        .ADDRW     (8),
        .DATAW     (32),
        .RESET_VAL (32'h0)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_axi_ctrl (bus),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_regs [8];
    logic [1:0]  resp;
    logic [31:0] rd;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [255:0] exp_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = exp_regs[i];
        return f;
    endfunction

    task automatic write_simple(input logic [7:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, output logic [1:0] r);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_rdy, w_rdy;
        bus.awaddr  = addr;  bus.awvalid = 1'b1;
        bus.wdata   = data;  bus.wstrb   = strb;  bus.wvalid = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_rdy = bus.awready;
            w_rdy  = bus.wready;
            tick();
            if (aw_rdy && bus.awvalid) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_rdy  && bus.wvalid)  begin w_done  = 1; bus.wvalid  = 1'b0; end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) check_val("wr_handshake_timeout", 256'(0), 256'(1));
        for (int i = 0; i < 20 && !bus.bvalid; i++) tick();
        if (!bus.bvalid) check_val("wr_bvalid_timeout", 256'(0), 256'(1));
        r = bus.bresp;
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        $display("WRITE addr=%02h data=%08h strb=%h bresp=%0d", addr, data, strb, r);
    endtask

    task automatic read_simple(input logic [7:0] addr, output logic [31:0] data,
                               output logic [1:0] r);
        bit ar_done = 0;
        bit ar_rdy;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            ar_rdy = bus.arready;
            tick();
            if (ar_rdy) ar_done = 1;
        end
        bus.arvalid = 1'b0;
        if (!ar_done) check_val("rd_handshake_timeout", 256'(0), 256'(1));
        for (int i = 0; i < 20 && !bus.rvalid; i++) tick();
        if (!bus.rvalid) check_val("rd_rvalid_timeout", 256'(0), 256'(1));
        data = bus.rdata;
        r    = bus.rresp;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        $display("READ  addr=%02h rdata=%08h rresp=%0d", addr, data, r);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // ---------------- Reset and release ----------------
        rst_i = 1'b1;
        repeat (3) tick();
        check_val("rst_awready", 256'(bus.awready), 256'(0));
        check_val("rst_wready",  256'(bus.wready),  256'(0));
        check_val("rst_arready", 256'(bus.arready), 256'(0));
        check_val("rst_bvalid",  256'(bus.bvalid),  256'(0));
        check_val("rst_rvalid",  256'(bus.rvalid),  256'(0));
        check_val("rst_bresp",   256'(bus.bresp),   256'(0));
        check_val("rst_rresp",   256'(bus.rresp),   256'(0));
        check_val("rst_rdata",   256'(bus.rdata),   256'(0));
        check_val("rst_pulse",   256'(wr_pulse_o),  256'(0));
        check_val("rst_regs",    regs_o,            exp_flat());
        rst_i = 1'b0;
        #1;
        check_val("rel_awready_early", 256'(bus.awready), 256'(0));
        tick();
        check_val("rel_awready", 256'(bus.awready), 256'(1));
        check_val("rel_wready",  256'(bus.wready),  256'(1));
        check_val("rel_arready", 256'(bus.arready), 256'(1));

        // ---------------- AW+W same cycle to reg 2 ----------------
        bus.awaddr = 8'h08; bus.awvalid = 1'b1;
        bus.wdata  = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check_val("t2_bvalid_early", 256'(bus.bvalid), 256'(0));
        check_val("t2_awready_full", 256'(bus.awready), 256'(0));
        tick();
        exp_regs[2] = 32'hDEADBEEF;
        check_val("t2_regs",   regs_o,              exp_flat());
        check_val("t2_pulse",  256'(wr_pulse_o),    256'(8'b0000_0100));
        check_val("t2_bvalid", 256'(bus.bvalid),    256'(1));
        check_val("t2_bresp",  256'(bus.bresp),     256'(0));
        tick();
        check_val("t2_pulse_off", 256'(wr_pulse_o), 256'(0));
        check_val("t2_bvalid_hold", 256'(bus.bvalid), 256'(1));
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check_val("t2_bvalid_clr", 256'(bus.bvalid), 256'(0));
        check_val("t2_awready_back", 256'(bus.awready), 256'(1));
        check_val("t2_wready_back",  256'(bus.wready),  256'(1));
        $display("WRITE addr=08 data=deadbeef strb=f (same-cycle AW/W)");

        // ---------------- Staggered AW then W, partial strobe ----------------
        write_simple(8'h0C, 32'hFFFFFFFF, 4'hF, resp);
        exp_regs[3] = 32'hFFFFFFFF;
        check_val("t3_pre_resp", 256'(resp), 256'(0));
        bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
        check_val("t3_awready_c0", 256'(bus.awready), 256'(1));
        tick();                                   // edge 0: AW handshake
        bus.awvalid = 1'b0;
        check_val("t3_awready_c1", 256'(bus.awready), 256'(0));
        check_val("t3_wready_c1",  256'(bus.wready),  256'(1));
        tick();
        check_val("t3_awready_c2", 256'(bus.awready), 256'(0));
        tick();
        check_val("t3_awready_c3", 256'(bus.awready), 256'(0));
        bus.wdata = 32'h12345678; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
        tick();                                   // edge 3: W handshake
        bus.wvalid = 1'b0;
        check_val("t3_bvalid_c3", 256'(bus.bvalid), 256'(0));
        tick();                                   // edge 4: commit
        exp_regs[3] = 32'hFFFF5678;
        check_val("t3_bvalid_c4", 256'(bus.bvalid), 256'(1));
        check_val("t3_regs",      regs_o,           exp_flat());
        check_val("t3_pulse",     256'(wr_pulse_o), 256'(8'b0000_1000));
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("t3_bvalid_hold",  256'(bus.bvalid),  256'(1));
            check_val("t3_bresp_hold",   256'(bus.bresp),   256'(0));
            check_val("t3_awready_hold", 256'(bus.awready), 256'(0));
            check_val("t3_wready_hold",  256'(bus.wready),  256'(0));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check_val("t3_bvalid_clr",   256'(bus.bvalid),  256'(0));
        check_val("t3_awready_back", 256'(bus.awready), 256'(1));
        $display("WRITE addr=0c data=12345678 strb=3 (AW then W)");

        // ---------------- Out-of-range write / read ----------------
        bus.awaddr = 8'h20; bus.awvalid = 1'b1;
        bus.wdata  = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick();
        check_val("t4_bvalid", 256'(bus.bvalid),  256'(1));
        check_val("t4_bresp",  256'(bus.bresp),   256'(2'b10));
        check_val("t4_pulse",  256'(wr_pulse_o),  256'(0));
        check_val("t4_regs",   regs_o,            exp_flat());
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        $display("WRITE addr=20 data=cafef00d strb=f (out of range)");
        read_simple(8'h20, rd, resp);
        check_val("t4_rd_data", 256'(rd),   256'(0));
        check_val("t4_rd_resp", 256'(resp), 256'(2'b10));
        read_simple(8'h1C, rd, resp);
        check_val("t4_last_data", 256'(rd),   256'(0));
        check_val("t4_last_resp", 256'(resp), 256'(0));
        read_simple(8'h0B, rd, resp);
        check_val("t4_lsb_ignored", 256'(rd), 256'(32'hDEADBEEF));

        // ---------------- Read held with RREADY low ----------------
        bus.araddr = 8'h0C; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check_val("t5_rvalid", 256'(bus.rvalid), 256'(1));
        check_val("t5_rdata",  256'(bus.rdata),  256'(32'hFFFF5678));
        check_val("t5_rresp",  256'(bus.rresp),  256'(0));
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("t5_rvalid_hold",  256'(bus.rvalid),  256'(1));
            check_val("t5_rdata_hold",   256'(bus.rdata),   256'(32'hFFFF5678));
            check_val("t5_arready_hold", 256'(bus.arready), 256'(0));
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check_val("t5_rvalid_clr",   256'(bus.rvalid),  256'(0));
        check_val("t5_arready_back", 256'(bus.arready), 256'(1));
        $display("READ  addr=0c rdata=ffff5678 (RREADY held low)");

        // ---------------- Zero strobe and upper-lane strobe ----------------
        bus.awaddr = 8'h08; bus.awvalid = 1'b1;
        bus.wdata  = 32'h00000000; bus.wstrb = 4'h0; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tick();
        check_val("t6_zs_bresp", 256'(bus.bresp),  256'(0));
        check_val("t6_zs_pulse", 256'(wr_pulse_o), 256'(8'b0000_0100));
        check_val("t6_zs_regs",  regs_o,           exp_flat());
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        $display("WRITE addr=08 data=00000000 strb=0");
        write_simple(8'h08, 32'h11223344, 4'hC, resp);
        exp_regs[2] = 32'h1122BEEF;
        check_val("t6_hi_regs", regs_o, exp_flat());

        // ---------------- Read colliding with commit ----------------
        bus.awaddr = 8'h08; bus.awvalid = 1'b1;
        bus.wdata  = 32'hA5A5A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();                                   // both buffers fill
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 8'h08; bus.arvalid = 1'b1;
        tick();                                   // commit and AR together
        bus.arvalid = 1'b0;
        exp_regs[2] = 32'hA5A5A5A5;
        check_val("t7_rvalid",   256'(bus.rvalid), 256'(1));
        check_val("t7_old_data", 256'(bus.rdata),  256'(32'h1122BEEF));
        check_val("t7_bvalid",   256'(bus.bvalid), 256'(1));
        check_val("t7_regs",     regs_o,           exp_flat());
        bus.rready = 1'b1; bus.bready = 1'b1;
        tick();
        bus.rready = 1'b0; bus.bready = 1'b0;
        $display("WRITE addr=08 data=a5a5a5a5 with same-edge READ");
        read_simple(8'h08, rd, resp);
        check_val("t7_new_data", 256'(rd), 256'(32'hA5A5A5A5));

        // ---------------- Reset with AW buffered ----------------
        bus.awaddr = 8'h04; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check_val("t8_aw_buffered", 256'(bus.awready), 256'(0));
        #2;
        rst_i = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
        check_val("t8_async_regs",   regs_o,           exp_flat());
        check_val("t8_async_bvalid", 256'(bus.bvalid), 256'(0));
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("t8_bvalid",  256'(bus.bvalid),  256'(0));
            check_val("t8_pulse",   256'(wr_pulse_o),  256'(0));
            check_val("t8_regs",    regs_o,            exp_flat());
            check_val("t8_awready", 256'(bus.awready), 256'(1));
        end
        $display("RESET with AW buffered, lone W afterwards");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
